// File: rtl/tc_pkg.sv
// Shared types and constants for the byte-serial adder scheduler.
package tc_pkg;

    localparam int unsigned ByteW = 8;

    typedef enum logic [1:0] {
        StIdle,
        StAdd,
        StResp
    } state_e;

endpackage

// File: rtl/tc_adder_sched_if.sv
// Request, shared-adder and response signals of tc_adder_sched.
interface tc_adder_sched_if #(
    parameter int unsigned NBYTES = 2
);
    import tc_pkg::*;

    localparam int unsigned W = ByteW * NBYTES;

    logic             req0_valid;
    logic [W-1:0]     req0_a;
    logic [W-1:0]     req0_b;
    logic             req0_cin;
    logic             req0_ready;

    logic             req1_valid;
    logic [W-1:0]     req1_a;
    logic [W-1:0]     req1_b;
    logic             req1_cin;
    logic             req1_ready;

    logic [ByteW-1:0] add_a;
    logic [ByteW-1:0] add_b;
    logic             add_cin;
    logic [ByteW-1:0] add_s;
    logic             add_cout;

    logic             rsp_valid;
    logic             rsp_id;
    logic [W:0]       rsp_sum;
    logic             rsp_ready;

    // Scheduler side.
    modport slave (
        input  req0_valid, req0_a, req0_b, req0_cin,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_cin,
        output req1_ready,
        output add_a, add_b, add_cin,
        input  add_s, add_cout,
        output rsp_valid, rsp_id, rsp_sum,
        input  rsp_ready
    );

    // Requesters, external adder and response consumer.
    modport master (
        output req0_valid, req0_a, req0_b, req0_cin,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_cin,
        input  req1_ready,
        input  add_a, add_b, add_cin,
        output add_s, add_cout,
        input  rsp_valid, rsp_id, rsp_sum,
        output rsp_ready
    );

endinterface

// File: rtl/tc_rr_arb2.sv
// Two-way round-robin grant; the pointer records the last requester served.
module tc_rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       en,
    input  logic       upd,
    input  logic       upd_id,
    output logic [1:0] gnt
);

    logic last_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else if (upd) begin
            last_q <= upd_id;
        end
    end

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = last_q ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/tc_adder_sched.sv
// Serves two requesters one at a time, feeding their operands byte by byte
// through a shared external 8-bit adder and returning {carry, sum}.
module tc_adder_sched
    import tc_pkg::*;
#(
    parameter int unsigned NBYTES = 2
) (
    input logic             clk,
    input logic             rst_n,
    tc_adder_sched_if.slave bus
);

    localparam int unsigned W     = ByteW * NBYTES;
    localparam logic [1:0]  KLast = 2'(NBYTES - 1);

    state_e     state_q, state_d;
    logic [1:0] k_q;
    logic       carry_q;
    logic       cin_q;
    logic       id_q;
    logic [W-1:0] a_q, b_q;
    logic [W-1:0] a_sh, b_sh;
    logic [W:0]   sum_q, sum_d;

    logic [1:0] req;
    logic [1:0] gnt;
    logic       accept;
    logic       rsp_done;
    logic       last_byte;

    assign req       = {bus.req1_valid, bus.req0_valid};
    assign accept    = |gnt;
    assign rsp_done  = (state_q == StResp) && bus.rsp_ready;
    assign last_byte = (k_q == KLast);
    assign a_sh      = a_q >> {k_q, 3'b000};
    assign b_sh      = b_q >> {k_q, 3'b000};

    tc_rr_arb2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .en     (state_q == StIdle),
        .upd    (rsp_done),
        .upd_id (id_q),
        .gnt    (gnt)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (|req)         state_d = StAdd;
            StAdd:   if (last_byte)    state_d = StResp;
            StResp:  if (bus.rsp_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Everything visible is forced low while reset is applied, even before the
    // first reset edge has cleared the registers.
    always_comb begin
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;
        bus.add_a      = '0;
        bus.add_b      = '0;
        bus.add_cin    = 1'b0;
        bus.rsp_valid  = 1'b0;
        bus.rsp_id     = 1'b0;
        if (rst_n) begin
            bus.req0_ready = gnt[0];
            bus.req1_ready = gnt[1];
            bus.rsp_valid  = (state_q == StResp);
            bus.rsp_id     = id_q;
            if (state_q == StAdd) begin
                bus.add_a   = a_sh[ByteW-1:0];
                bus.add_b   = b_sh[ByteW-1:0];
                bus.add_cin = (k_q == 2'd0) ? cin_q : carry_q;
            end
        end
    end

    assign bus.rsp_sum = sum_q;

    always_comb begin
        sum_d = sum_q;
        if (state_q == StAdd) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (k_q == 2'(i)) sum_d[i*ByteW +: ByteW] = bus.add_s;
            end
            if (last_byte) sum_d[W] = bus.add_cout;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            k_q     <= 2'd0;
            carry_q <= 1'b0;
            cin_q   <= 1'b0;
            id_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
        end else if (accept) begin
            k_q     <= 2'd0;
            carry_q <= 1'b0;
            id_q    <= gnt[1];
            a_q     <= gnt[1] ? bus.req1_a   : bus.req0_a;
            b_q     <= gnt[1] ? bus.req1_b   : bus.req0_b;
            cin_q   <= gnt[1] ? bus.req1_cin : bus.req0_cin;
        end else if (state_q == StAdd) begin
            k_q     <= k_q + 2'd1;
            carry_q <= bus.add_cout;
            sum_q   <= sum_d;
        end
    end

endmodule

// File: tb/tb_tc_adder_sched.sv
// Self-checking bench: arithmetic/queue model of the scheduler plus directed vectors.
module tb_tc_adder_sched;
    import tc_pkg::*;

    localparam int unsigned NB = 2;
    localparam int unsigned W  = ByteW * NB;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tc_adder_sched_if #(.NBYTES(NB)) bus ();

    tc_adder_sched #(.NBYTES(NB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Behavioural stand-in for the external 8-bit adder.
    assign {bus.add_cout, bus.add_s} = 9'(bus.add_a) + 9'(bus.add_b) + 9'(bus.add_cin);

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: idle/busy, cycles since accept, latched transaction, last-served.
    bit      chk_en = 1'b0;
    bit      m_busy = 1'b0;
    int      m_cnt  = 0;
    bit      m_id   = 1'b0;
    bit      m_last = 1'b1;
    longint  m_a, m_b;
    bit      m_cin;
    logic [1:0] v, exp_g;
    longint  mask, e_a, e_b;
    bit      e_c;
    int      k;

    always @(negedge clk) begin
        if (chk_en) begin
            v = {bus.req1_valid, bus.req0_valid};
            if (!rst_n) begin
                check("reset_ready", {bus.req1_ready, bus.req0_ready}, 2'b00);
                check("reset_rsp", {bus.rsp_valid, bus.rsp_id}, 2'b00);
                check("reset_add", {bus.add_a, bus.add_b, bus.add_cin}, 17'h0);
                m_busy = 1'b0;
                m_last = 1'b1;
            end else begin
                exp_g = 2'b00;
                if (!m_busy) exp_g = (v == 2'b11) ? (m_last ? 2'b01 : 2'b10) : v;
                check("ready", {bus.req1_ready, bus.req0_ready}, exp_g);
                check("rsp_valid", bus.rsp_valid, m_busy && m_cnt >= NB + 1);
                if (m_busy && m_cnt >= NB + 1) begin
                    check("rsp_id", bus.rsp_id, m_id);
                    check("rsp_sum", bus.rsp_sum, m_a + m_b + m_cin);
                end
                e_a = 0; e_b = 0; e_c = 0;
                if (m_busy && m_cnt >= 1 && m_cnt <= NB) begin
                    k    = m_cnt - 1;
                    mask = (64'd1 << (8 * k)) - 1;
                    e_a  = (m_a >> (8 * k)) & 255;
                    e_b  = (m_b >> (8 * k)) & 255;
                    e_c  = (k == 0) ? m_cin
                         : 1'((((m_a & mask) + (m_b & mask) + m_cin) >> (8 * k)) & 1);
                end
                check("add_bus", {bus.add_a, bus.add_b, bus.add_cin}, {e_a[7:0], e_b[7:0], e_c});
                if (!m_busy) begin
                    if (exp_g != 2'b00) begin
                        m_busy = 1'b1;
                        m_cnt  = 1;
                        m_id   = exp_g[1];
                        m_a    = m_id ? longint'(bus.req1_a) : longint'(bus.req0_a);
                        m_b    = m_id ? longint'(bus.req1_b) : longint'(bus.req0_b);
                        m_cin  = m_id ? bus.req1_cin : bus.req0_cin;
                    end
                end else if (m_cnt >= NB + 1) begin
                    if (bus.rsp_ready) begin
                        m_busy = 1'b0;
                        m_last = m_id;
                    end
                end else begin
                    m_cnt++;
                end
            end
        end
    end

    task automatic idle_inputs();
        bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_cin = 1'b0;
        bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_cin = 1'b0;
        bus.rsp_ready  = 1'b1;
    endtask

    task automatic do_reset(input int n);
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (n) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic drive_req(input int r, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic cin);
        if (r == 0) begin
            bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b; bus.req0_cin = cin;
        end else begin
            bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b; bus.req1_cin = cin;
        end
    endtask

    task automatic do_txn(input int r, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, output logic id, output logic [W:0] sum,
                          output int lat, output logic hi_cin);
        int t0 = -1;
        id = 1'bx; sum = 'x; lat = -1; hi_cin = 1'bx;
        @(posedge clk); #1;
        drive_req(r, a, b, cin);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ((r == 0) ? bus.req0_ready : bus.req1_ready) begin
                t0 = cyc;
                break;
            end
        end
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        if (t0 < 0) begin
            check("accept_timeout", 0, 1);
            return;
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cyc == t0 + NB) hi_cin = bus.add_cin;
            if (bus.rsp_valid) begin
                lat = cyc - t0;
                id  = bus.rsp_id;
                sum = bus.rsp_sum;
                break;
            end
        end
        if (lat < 0) check("rsp_timeout", 0, 1);
    endtask

    logic       r_id, r_hc;
    logic [W:0] r_sum;
    int         r_lat;
    int         grants[$];
    int         hs;
    bit         seen;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        @(posedge clk);
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_sum", bus.rsp_sum, 17'h0);
        check("post_reset_valid", bus.rsp_valid, 1'b0);

        // Low byte carries into the high byte.
        do_txn(0, 16'h00FF, 16'h0001, 1'b0, r_id, r_sum, r_lat, r_hc);
        check("t1_latency", r_lat, 3);
        check("t1_id", r_id, 1'b0);
        check("t1_sum", r_sum, 17'h00100);

        // Carry-in ripples to the final carry.
        do_txn(0, 16'hFFFF, 16'h0000, 1'b1, r_id, r_sum, r_lat, r_hc);
        check("t2_sum", r_sum, 17'h10000);
        check("t2_hi_cin", r_hc, 1'b1);

        do_txn(1, 16'h1234, 16'hEDCC, 1'b1, r_id, r_sum, r_lat, r_hc);
        check("t3_id", r_id, 1'b1);
        check("t3_sum", r_sum, 17'h10001);

        // Both held: fresh reset makes requester 0 win the first tie.
        do_reset(2);
        @(posedge clk); #1;
        drive_req(0, 16'h0102, 16'h0304, 1'b0);
        drive_req(1, 16'hF00F, 16'h0FF1, 1'b1);
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (bus.req0_ready) grants.push_back(0);
            if (bus.req1_ready) grants.push_back(1);
        end
        @(posedge clk); #1;
        idle_inputs();
        repeat (8) @(posedge clk);
        check("rr_count_ge4", grants.size() >= 4, 1'b1);
        for (int i = 0; i < 4; i++) begin
            check("rr_order", (grants.size() > i) ? grants[i] : 9, i % 2);
        end

        // Backpressure with a competing requester waiting.
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        drive_req(0, 16'hABCD, 16'h1111, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.req0_ready) begin seen = 1'b1; break; end
        end
        check("bp_accept", seen, 1'b1);
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        drive_req(1, 16'h0001, 16'h0002, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin seen = 1'b1; break; end
        end
        check("bp_rsp_seen", seen, 1'b1);
        check("bp_sum", bus.rsp_sum, 17'h0BCDE);
        r_sum = bus.rsp_sum;
        r_id  = bus.rsp_id;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold", {bus.rsp_valid, bus.rsp_id, bus.rsp_sum}, {1'b1, r_id, r_sum});
            check("bp_no_ready", {bus.req1_ready, bus.req0_ready}, 2'b00);
        end
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_next_accept", bus.req1_ready, 1'b1);
        @(posedge clk); #1;
        bus.req1_valid = 1'b0;
        repeat (6) @(posedge clk);

        // Reset in the middle of ADD abandons the transaction.
        @(posedge clk); #1;
        drive_req(0, 16'h5555, 16'h5555, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.req0_ready) begin seen = 1'b1; break; end
        end
        check("rst_accept", seen, 1'b1);
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_out", {bus.rsp_valid, bus.rsp_id, bus.rsp_sum}, 19'h0);
        check("rst_ready", {bus.req1_ready, bus.req0_ready}, 2'b00);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("rst_no_stale", bus.rsp_valid, 1'b0);
        end
        do_txn(0, 16'h0F0F, 16'h00F1, 1'b0, r_id, r_sum, r_lat, r_hc);
        check("rst_after_sum", r_sum, 17'h01000);
        check("rst_after_lat", r_lat, 3);

        // Random traffic; the model checks every cycle.
        hs = 0;
        for (int i = 0; i < 4000 && hs < 200; i++) begin
            @(posedge clk); #1;
            bus.req0_valid = ($urandom_range(9) < 7);
            bus.req0_a     = W'($urandom);
            bus.req0_b     = W'($urandom);
            bus.req0_cin   = 1'($urandom);
            bus.req1_valid = ($urandom_range(9) < 7);
            bus.req1_a     = W'($urandom);
            bus.req1_b     = W'($urandom);
            bus.req1_cin   = 1'($urandom);
            bus.rsp_ready  = ($urandom_range(3) != 0);
            @(negedge clk);
            if (bus.rsp_valid && bus.rsp_ready) hs++;
        end
        @(posedge clk); #1;
        idle_inputs();
        repeat (8) @(posedge clk);
        check("random_200_done", hs >= 200, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tc_adder_sched.md
TC_ADDER_SCHED -- requirements
Module: tc_adder_sched

Interface
REQ-001 Parameter NBYTES, default 2, operand width in bytes; legal range 1..4.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst_n  input  1  synchronous, active-low reset, sampled on posedge clk.
REQ-004 req0_valid  input  1  requester 0 has an add pending.
REQ-005 req0_a, req0_b  input  8*NBYTES each  requester 0 operands.
REQ-006 req0_cin  input  1  requester 0 carry-in.
REQ-007 req0_ready  output  1  requester 0 operands accepted this cycle.
REQ-008 req1_valid, req1_a, req1_b, req1_cin, req1_ready  same as REQ-004..007, for requester 1.
REQ-009 add_a, add_b  output  8 each  byte operands driven to the shared 8-bit mirror adder.
REQ-010 add_cin  output  1  carry-in to the shared adder.
REQ-011 add_s  input  8  adder sum, combinational from add_a, add_b and add_cin in the same cycle.
REQ-012 add_cout  input  1  adder carry-out.
REQ-013 rsp_valid  output  1  result available.
REQ-014 rsp_id  output  1  requester that owns the result.
REQ-015 rsp_sum  output  8*NBYTES+1  result {carry, sum}.
REQ-016 rsp_ready  input  1  consumer accepts the result.

Function
REQ-017 States: IDLE, ADD, RESP; one transaction in flight at a time.
REQ-018 IDLE: if any reqX_valid, grant one requester, assert its reqX_ready for exactly that cycle, latch its operands and cin, clear byte counter, go to ADD.
REQ-019 Arbitration: round-robin; if both are valid, grant the requester not served last; a single valid requester is granted regardless of history.
REQ-020 reqX_ready is never asserted outside IDLE and never for both requesters in the same cycle.
REQ-021 ADD, byte k: drive add_a/add_b = byte k of the latched operands; add_cin = latched cin for k=0, otherwise the registered carry.
REQ-022 ADD, byte k: capture add_s into result byte k and add_cout into the carry register; increment k.
REQ-023 ADD exits to RESP after byte NBYTES-1; rsp_sum[8*NBYTES] = final carry.
REQ-024 RESP: hold rsp_valid=1 with stable rsp_id and rsp_sum until rsp_ready=1; on that cycle update the last-served pointer and go to IDLE.
REQ-025 Latency: accept at cycle T; rsp_valid rises at T+NBYTES+1; accepts are spaced at least NBYTES+2 cycles apart.
REQ-026 Outside ADD, add_a, add_b and add_cin are driven to 0.
REQ-027 Requester valid changes while the block is busy have no effect on the transaction in flight.
REQ-028 Arithmetic is unsigned: rsp_sum = a + b + cin, computed modulo 2^(8*NBYTES+1); this is exact, so there is no overflow.

Reset
REQ-029 While rst_n=0 at posedge clk: state becomes IDLE, k=0, carry=0, the last-served pointer is set to requester 1 (so requester 0 wins the first tie), and rsp_sum=0.
REQ-030 During reset: rsp_valid=0, rsp_id=0, req0_ready=req1_ready=0, add_a=add_b=add_cin=0.
REQ-031 Reset asserted mid-ADD or mid-RESP abandons the transaction; no response is issued for it.

Structure
REQ-032 A shared package tc_pkg holds the state enumeration (IDLE/ADD/RESP) and the byte-width constant 8.
REQ-033 One sub-module, tc_rr_arb2 (2-way round-robin grant with a last-served pointer), is instantiated once; the adder itself stays external.

Verification
REQ-034 NBYTES=2, req0 only: a=16'h00FF, b=16'h0001, cin=0 -> rsp_valid at T+3, rsp_id=0, rsp_sum=17'h00100.
REQ-035 Carry out: a=16'hFFFF, b=16'h0000, cin=1 -> rsp_sum=17'h10000; in the HI byte cycle, add_cin=1.
REQ-036 Both requesters valid, held continuously, rsp_ready=1 -> grants alternate 0,1,0,1 starting with 0; readies are never simultaneous.
REQ-037 Backpressure: rsp_ready=0 for 5 cycles -> rsp_valid, rsp_id and rsp_sum are held stable and no new req ready is asserted; first cycle with rsp_ready=1 -> next accept follows.
REQ-038 Reset asserted mid-ADD, then released -> outputs return to their reset values, no stale rsp_valid, and the next request completes correctly.
REQ-039 Random 200 transactions against a reference model with a behavioural 8-bit adder -> rsp_sum and rsp_id match every time.
